ysyx_22040759_gpr_wb_ctrl: RTL and testbench

Write-port scheduler and scoreboard for the 32x64 GPR file.
- Shares the single GPR write port between two writeback requesters: EXU (ALU/CSR results) and LSU (load data). Grants are round-robin.
- Tracks destination registers that have been issued but not yet written back.
- Stalls issue on RAW/WAW hazards.
- Sits between IDU issue, EXU/LSU writeback and the GPR write port.

---
 rtl/ysyx_22040759_gpr_wb_ctrl_pkg.sv | 19 +
 rtl/ysyx_22040759_rr_arb2.sv | 39 +++
 rtl/ysyx_22040759_gpr_wb_ctrl.sv | 120 ++++++++++++
 tb/tb_ysyx_22040759_gpr_wb_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040759_gpr_wb_ctrl_pkg.sv
// Shared definitions for the GPR writeback controller: widths, grant
// encodings and the writeback request bundle.
package ysyx_22040759_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  // Grant encodings; the arbiter remembers the last winner with these.
  localparam logic REQ_EXU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  typedef struct packed {
    logic            valid;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/ysyx_22040759_rr_arb2.sv
// Two-way round-robin arbiter between the EXU and LSU writeback requesters.
// When both request, the one that did not win last time is granted.
module ysyx_22040759_rr_arb2
  import ysyx_22040759_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_exu_i,
  input  logic req_lsu_i,
  output logic gnt_valid_o,
  output logic gnt_sel_o
);

  logic rr_last_q;
  logic rr_last_d;

  // Pick a winner this cycle and remember it for the next tie.
  always_comb begin
    gnt_valid_o = req_exu_i | req_lsu_i;
    if (req_exu_i && req_lsu_i) begin
      gnt_sel_o = (rr_last_q == REQ_EXU) ? REQ_LSU : REQ_EXU;
    end else if (req_lsu_i) begin
      gnt_sel_o = REQ_LSU;
    end else begin
      gnt_sel_o = REQ_EXU;
    end
    rr_last_d = gnt_valid_o ? gnt_sel_o : rr_last_q;
  end

  // Last-winner register; starts at EXU so the LSU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_last_q <= REQ_EXU;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/ysyx_22040759_gpr_wb_ctrl.sv
// GPR write-port scheduler and scoreboard. Shares the single GPR write port
// between EXU and LSU writebacks, tracks destinations issued but not yet
// written back, and stalls issue on RAW/WAW hazards against them.
module ysyx_22040759_gpr_wb_ctrl
  import ysyx_22040759_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  output logic            iss_ready,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_wen,
  input  logic            exu_valid,
  output logic            exu_ready,
  input  logic [AW-1:0]   exu_rd,
  input  logic [XLEN-1:0] exu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            gpr_wen,
  output logic [AW-1:0]   gpr_waddr,
  output logic [XLEN-1:0] gpr_wdata,
  output logic [NREG-1:0] busy_vec
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            gpr_wen_q;
  logic            gpr_wen_d;
  logic [AW-1:0]   gpr_waddr_q;
  logic [AW-1:0]   gpr_waddr_d;
  logic [XLEN-1:0] gpr_wdata_q;
  logic [XLEN-1:0] gpr_wdata_d;

  wb_req_t exu_req;
  wb_req_t lsu_req;
  wb_req_t win_req;
  logic    gnt_valid;
  logic    gnt_sel;
  logic    hazard;
  logic    iss_fire;

  assign exu_req = '{valid: exu_valid, rd: exu_rd, data: exu_data};
  assign lsu_req = '{valid: lsu_valid, rd: lsu_rd, data: lsu_data};

  // Nothing is granted while reset is held, so requesters keep holding.
  ysyx_22040759_rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_exu_i   (exu_req.valid & ~rst),
    .req_lsu_i   (lsu_req.valid & ~rst),
    .gnt_valid_o (gnt_valid),
    .gnt_sel_o   (gnt_sel)
  );

  // Issue handshake: any busy source, or a busy destination that is about
  // to be overwritten, holds the instruction back.
  always_comb begin
    hazard    = busy_q[iss_rs1] | busy_q[iss_rs2] | (iss_wen & busy_q[iss_rd]);
    iss_ready = ~hazard;
    iss_fire  = iss_valid & iss_ready;
    exu_ready = gnt_valid & (gnt_sel == REQ_EXU);
    lsu_ready = gnt_valid & (gnt_sel == REQ_LSU);
    win_req   = (gnt_sel == REQ_LSU) ? lsu_req : exu_req;
  end

  // Write-port next state: a grant to x0 is swallowed, no grant holds the
  // address/data so the port only toggles on real writes.
  always_comb begin
    gpr_wen_d   = 1'b0;
    gpr_waddr_d = gpr_waddr_q;
    gpr_wdata_d = gpr_wdata_q;
    if (gnt_valid && win_req.valid && (win_req.rd != '0)) begin
      gpr_wen_d   = 1'b1;
      gpr_waddr_d = win_req.rd;
      gpr_wdata_d = win_req.data;
    end
  end

  // Scoreboard next state: clear on the edge the GPR takes the write, set on
  // issue. WAW stalls guarantee these never hit the same register at once.
  always_comb begin
    busy_d = busy_q;
    if (gpr_wen_q) begin
      busy_d[gpr_waddr_q] = 1'b0;
    end
    if (iss_fire && iss_wen && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset drops any grant that was already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q      <= '0;
      gpr_wen_q   <= 1'b0;
      gpr_waddr_q <= '0;
      gpr_wdata_q <= '0;
    end else begin
      busy_q      <= busy_d;
      gpr_wen_q   <= gpr_wen_d;
      gpr_waddr_q <= gpr_waddr_d;
      gpr_wdata_q <= gpr_wdata_d;
    end
  end

  assign gpr_wen   = gpr_wen_q;
  assign gpr_waddr = gpr_waddr_q;
  assign gpr_wdata = gpr_wdata_q;
  assign busy_vec  = busy_q;

  // A writeback should only ever land on a register that issue marked busy.
  spurious_wb_a : assert property (@(posedge clk) disable iff (rst)
    gpr_wen_q |-> busy_q[gpr_waddr_q]);

endmodule

// File: tb/tb_ysyx_22040759_gpr_wb_ctrl.sv
// Testbench for the GPR writeback controller: directed scenarios with literal
// expectations, then random issue/writeback traffic against a reference model.
module tb_ysyx_22040759_gpr_wb_ctrl;
  import ysyx_22040759_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            iss_valid, iss_ready, iss_wen;
  logic [AW-1:0]   iss_rs1, iss_rs2, iss_rd;
  logic            exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [AW-1:0]   exu_rd, lsu_rd;
  logic [XLEN-1:0] exu_data, lsu_data;
  logic            gpr_wen;
  logic [AW-1:0]   gpr_waddr;
  logic [XLEN-1:0] gpr_wdata;
  logic [NREG-1:0] busy_vec;

  ysyx_22040759_gpr_wb_ctrl dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_rs1(iss_rs1),
    .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_wen(iss_wen),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wbItem_t;

  wbItem_t exuQ[$];
  wbItem_t lsuQ[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: set of registers awaiting writeback, the last arbitration
  // winner, and the write the port must show in the following cycle.
  bit              mValid = 1'b0;
  bit              pend[NREG];
  bit              mLastLsu;
  bit              mWen;
  logic [AW-1:0]   mWaddr;
  logic [XLEN-1:0] mWdata;
  bit              expIssRdy, expExuRdy, expLsuRdy;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare outputs against the model each cycle, then advance the model.
  always @(negedge clk) begin
    logic [NREG-1:0] busyExp;
    bit exuWins, lsuWins;
    for (int r = 0; r < NREG; r++) busyExp[r] = pend[r];
    exuWins = 1'b0; lsuWins = 1'b0;
    expIssRdy = 1'b0; expExuRdy = 1'b0; expLsuRdy = 1'b0;
    if (mValid) begin
      checkOutput("gpr_wen", gpr_wen, mWen);
      checkOutput("busy_vec", busy_vec, busyExp);
      if (mWen) begin
        checkOutput("gpr_waddr", gpr_waddr, mWaddr);
        checkOutput("gpr_wdata", gpr_wdata, mWdata);
      end
    end
    if (mValid && !rst) begin
      expIssRdy = !(pend[iss_rs1] || pend[iss_rs2] || (iss_wen && pend[iss_rd]));
      if (exu_valid && lsu_valid) begin
        lsuWins = !mLastLsu;
        exuWins = mLastLsu;
      end else begin
        exuWins = exu_valid;
        lsuWins = lsu_valid;
      end
      expExuRdy = exuWins;
      expLsuRdy = lsuWins;
      checkOutput("iss_ready", iss_ready, expIssRdy);
      checkOutput("exu_ready", exu_ready, expExuRdy);
      checkOutput("lsu_ready", lsu_ready, expLsuRdy);
    end
    if (rst) begin
      mValid = 1'b1;
      for (int r = 0; r < NREG; r++) pend[r] = 1'b0;
      mLastLsu = 1'b0; mWen = 1'b0; mWaddr = '0; mWdata = '0;
    end else if (mValid) begin
      if (mWen) pend[mWaddr] = 1'b0;
      if (iss_valid && expIssRdy && iss_wen && iss_rd != 0) pend[iss_rd] = 1'b1;
      mWen = 1'b0;
      if (exuWins || lsuWins) begin
        mLastLsu = lsuWins;
        if (lsuWins && lsu_rd != 0) begin
          mWen = 1'b1; mWaddr = lsu_rd; mWdata = lsu_data;
        end else if (exuWins && exu_rd != 0) begin
          mWen = 1'b1; mWaddr = exu_rd; mWdata = exu_data;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issueOne(input logic [AW-1:0] rd);
    iss_valid = 1'b1; iss_rs1 = '0; iss_rs2 = '0; iss_rd = rd; iss_wen = 1'b1;
    step();
    iss_valid = 1'b0;
  endtask

  // Retire the handshakes of the cycle that just ended into the agent queues.
  task automatic consumeHandshakes(output bit exuHold, output bit lsuHold);
    wbItem_t item;
    if (iss_valid && expIssRdy && iss_wen) begin
      item.rd   = iss_rd;
      item.data = {$urandom, $urandom};
      if ($urandom_range(1, 0) == 1) exuQ.push_back(item);
      else lsuQ.push_back(item);
    end
    exuHold = exu_valid && !expExuRdy;
    lsuHold = lsu_valid && !expLsuRdy;
    if (exu_valid && expExuRdy) void'(exuQ.pop_front());
    if (lsu_valid && expLsuRdy) void'(lsuQ.pop_front());
  endtask

  task automatic applyStimulus(input bit enIssue, input bit exuHold, input bit lsuHold);
    iss_valid = enIssue && ($urandom_range(1, 0) == 1);
    iss_rs1   = AW'($urandom_range(7, 0));
    iss_rs2   = AW'($urandom_range(7, 0));
    iss_rd    = AW'($urandom_range(7, 0));
    iss_wen   = ($urandom_range(3, 0) != 0);
    if (exuQ.size() == 0) exu_valid = 1'b0;
    else begin
      if (!exuHold) exu_valid = ($urandom_range(3, 0) != 0);
      exu_rd = exuQ[0].rd; exu_data = exuQ[0].data;
    end
    if (lsuQ.size() == 0) lsu_valid = 1'b0;
    else begin
      if (!lsuHold) lsu_valid = ($urandom_range(3, 0) != 0);
      lsu_rd = lsuQ[0].rd; lsu_data = lsuQ[0].data;
    end
  endtask

  initial begin
    #1_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    bit eh, lh;
    int drain;
    rst = 1'b1;
    iss_valid = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_wen = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    step(); step();
    rst = 1'b0;

    // Reset state and idle issue readiness.
    iss_rs1 = 5; iss_rs2 = 6; iss_rd = 7; iss_wen = 1;
    @(negedge clk);
    checkOutput("rst_busy", busy_vec, 0);
    checkOutput("rst_wen", gpr_wen, 0);
    checkOutput("rst_waddr", gpr_waddr, 0);
    checkOutput("rst_wdata", gpr_wdata, 0);
    checkOutput("idle_iss_ready", iss_ready, 1);
    step();

    // RAW stall until the EXU writeback of x7 lands.
    iss_valid = 1; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 7; iss_wen = 1;
    @(negedge clk); checkOutput("issue_x7", iss_ready, 1);
    step();
    iss_rs1 = 7; iss_rd = 8; iss_wen = 0;
    @(negedge clk);
    checkOutput("raw_stall", iss_ready, 0);
    checkOutput("busy_x7", busy_vec, 64'h80);
    step(); step();
    exu_valid = 1; exu_rd = 7; exu_data = 64'hDEAD;
    @(negedge clk); checkOutput("exu_grant", exu_ready, 1);
    step();
    exu_valid = 0;
    @(negedge clk);
    checkOutput("wb_wen", gpr_wen, 1);
    checkOutput("wb_waddr", gpr_waddr, 7);
    checkOutput("wb_wdata", gpr_wdata, 64'hDEAD);
    checkOutput("raw_still_stalled", iss_ready, 0);
    step();
    @(negedge clk);
    checkOutput("raw_release", iss_ready, 1);
    checkOutput("busy_cleared", busy_vec, 0);
    step();
    iss_valid = 0;

    // Simultaneous requests: LSU first, then EXU, back to back.
    issueOne(3); issueOne(4);
    exu_valid = 1; exu_rd = 3; exu_data = 64'h11;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 64'h22;
    @(negedge clk);
    checkOutput("tie1_lsu", lsu_ready, 1);
    checkOutput("tie1_exu", exu_ready, 0);
    step();
    lsu_valid = 0;
    @(negedge clk);
    checkOutput("tie2_exu", exu_ready, 1);
    checkOutput("tie_wr1_addr", gpr_waddr, 4);
    checkOutput("tie_wr1_data", gpr_wdata, 64'h22);
    step();
    exu_valid = 0;
    @(negedge clk);
    checkOutput("tie_wr2_wen", gpr_wen, 1);
    checkOutput("tie_wr2_addr", gpr_waddr, 3);
    checkOutput("tie_wr2_data", gpr_wdata, 64'h11);
    step();

    // WAW stall on a busy destination, released when the write is dropped.
    issueOne(9);
    iss_valid = 1; iss_rs1 = 1; iss_rs2 = 2; iss_rd = 9; iss_wen = 1;
    @(negedge clk); checkOutput("waw_stall", iss_ready, 0);
    step();
    iss_wen = 0;
    @(negedge clk); checkOutput("waw_no_wen", iss_ready, 1);
    step();
    iss_valid = 0;
    exu_valid = 1; exu_rd = 9; exu_data = 64'h99;
    step();
    exu_valid = 0;
    issueOne(12);

    // Write to x0 is consumed; x9 clear and x12 set shared one edge.
    lsu_valid = 1; lsu_rd = 0; lsu_data = 64'hFF;
    @(negedge clk);
    checkOutput("x0_lsu_grant", lsu_ready, 1);
    checkOutput("set_clear_same_edge", busy_vec, 64'h1000);
    step();
    lsu_valid = 0;
    @(negedge clk);
    checkOutput("x0_no_write", gpr_wen, 0);
    checkOutput("x0_busy_same", busy_vec, 64'h1000);
    step();

    // Reset with a write in flight and x12 busy; arbiter back to LSU-first.
    issueOne(13);
    lsu_valid = 1; lsu_rd = 13; lsu_data = 64'h1313;
    @(negedge clk); checkOutput("pre_rst_busy", busy_vec, 64'h3000);
    step();
    lsu_valid = 0; rst = 1;
    @(negedge clk); checkOutput("pre_rst_wen", gpr_wen, 1);
    step();
    rst = 0;
    @(negedge clk);
    checkOutput("post_rst_wen", gpr_wen, 0);
    checkOutput("post_rst_busy", busy_vec, 0);
    step();
    issueOne(14); issueOne(15);
    exu_valid = 1; exu_rd = 14; exu_data = 64'h14;
    lsu_valid = 1; lsu_rd = 15; lsu_data = 64'h15;
    @(negedge clk);
    checkOutput("post_rst_tie_lsu", lsu_ready, 1);
    checkOutput("post_rst_tie_exu", exu_ready, 0);
    step();
    lsu_valid = 0;
    @(negedge clk); checkOutput("post_rst_exu_next", exu_ready, 1);
    step();
    exu_valid = 0;
    step(); step();

    // Random issue and writeback traffic.
    for (int c = 0; c < 3000; c++) begin
      step();
      consumeHandshakes(eh, lh);
      applyStimulus(1'b1, eh, lh);
    end
    drain = 0;
    do begin
      step();
      consumeHandshakes(eh, lh);
      applyStimulus(1'b0, eh, lh);
      drain++;
    end while ((exuQ.size() > 0 || lsuQ.size() > 0) && drain < 300);
    checkOutput("drain_complete", exuQ.size() + lsuQ.size(), 0);
    step(); step();
    @(negedge clk);
    checkOutput("final_busy", busy_vec, 0);
    checkOutput("final_wen", gpr_wen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
